bls12_381_inst_fetch: RTL and testbench
=======================================

BLS12_381_INST_FETCH -- requirements
Module: bls12_381_inst_fetch

Interface
REQ-001 Parameter READ_CYCLE, default 3: instruction RAM read latency in cycles, from o_ram_re to i_ram_dat valid.
REQ-002 Parameter ADDR_W, default INST_RAM_DEPTH: instruction RAM address width.
REQ-003 i_clk  in  1  single clock; all logic on its rising edge.
REQ-004 i_rst_n  in  1  reset, asynchronous and active-low.
REQ-005 i_start  in  1  one-cycle pulse that starts a program at i_start_pc; ignored unless the block is IDLE.
REQ-006 i_start_pc  in  ADDR_W  first instruction address.
REQ-007 i_abort  in  1  level; forces IDLE.
REQ-008 o_ram_addr  out  ADDR_W  instruction RAM read address.
REQ-009 o_ram_re  out  1  one-cycle read strobe.
REQ-010 i_ram_dat  in  $bits(inst_t)  read data, valid READ_CYCLE cycles after o_ram_re.
REQ-011 o_inst  out  $bits(inst_t)  instruction to the execution units.
REQ-012 o_inst_val / i_inst_rdy  out / in  1 / 1  valid/ready dispatch handshake.
REQ-013 o_irq  out  1  one-cycle interrupt pulse.
REQ-014 o_irq_idx  out  16  interrupt payload (inst.a).
REQ-015 o_busy  out  1  high in every state except IDLE.
REQ-016 o_err  out  1  sticky illegal-opcode flag; cleared only by i_start or reset.
REQ-017 o_pc  out  ADDR_W  address of the current instruction.

Function
REQ-018 The block SHALL have the states IDLE, FETCH, WAIT_RD, DECODE, DISPATCH and DELAY.
REQ-019 IDLE: on i_start, the block SHALL load pc=i_start_pc, clear o_err and go to FETCH.
REQ-020 FETCH: the block SHALL assert o_ram_re for 1 cycle with o_ram_addr=pc, then go to WAIT_RD.
REQ-021 WAIT_RD: the block SHALL count READ_CYCLE cycles from o_ram_re, capture i_ram_dat into an instruction register, then go to DECODE.
REQ-022 DECODE, NOOP_WAIT with a==0: the block SHALL end the program and go to IDLE.
REQ-023 DECODE, NOOP_WAIT with a!=0: the block SHALL go to DELAY with a 16-bit counter loaded with a.
REQ-024 DELAY: the counter SHALL decrement each cycle, and the block SHALL advance when it reaches 0, giving exactly a cycles in DELAY.
REQ-025 DECODE, SEND_INTERRUPT: the block SHALL pulse o_irq for 1 cycle with o_irq_idx=a, then advance.
REQ-026 DECODE, COPY_REG, SUB/ADD/MUL/INV_ELEMENT, POINT_MULT, FP_FPOINT_MULT or FP2_FPOINT_MULT: the block SHALL go to DISPATCH.
REQ-027 DECODE, any other code: the block SHALL set o_err and go to IDLE.
REQ-028 DISPATCH: o_inst_val SHALL be high with o_inst stable until i_inst_rdy is sampled high, and the block SHALL then advance.
REQ-029 o_inst_val SHALL NOT depend combinationally on i_inst_rdy.
REQ-030 Advance SHALL mean pc <= pc+1, wrapping modulo 2^ADDR_W (max address -> 0), then FETCH.
REQ-031 Dispatch latency SHALL be 1 (FETCH) + READ_CYCLE + 1 (DECODE) cycles from entering FETCH to o_inst_val high, i.e. 5 cycles at default.
REQ-032 i_abort SHALL take priority over all transitions: next state IDLE, o_inst_val, o_ram_re and o_irq low next cycle, pc retained, o_err retained.
REQ-033 If i_start and i_abort are high together, i_abort SHALL win.
REQ-034 Read data returning after an abort SHALL be ignored.
REQ-035 In every state other than DISPATCH, o_inst_val SHALL be 0.
REQ-036 Only one RAM read SHALL be outstanding at a time.

Reset
REQ-037 Assertion of i_rst_n low SHALL immediately force: state IDLE, pc 0, o_ram_re 0, o_ram_addr 0, o_inst 0, o_inst_val 0, o_irq 0, o_irq_idx 0, o_busy 0, o_err 0, o_pc 0, delay and read counters 0.
REQ-038 Reset deassertion SHALL be synchronised externally; the block SHALL start no action before i_start.

Structure
REQ-039 inst_t, code_t, READ_CYCLE and INST_RAM_DEPTH SHALL come from bls12_381_pkg, with no local redefinition.
REQ-040 Any new opcode SHALL be added to code_t in bls12_381_pkg only.
REQ-041 The block SHALL be a single module with no sub-modules; the decoder is an inline case on code_t.

Verification
REQ-042 The bench SHALL cover: RAM[0]=ADD_ELEMENT(a=1,b=2,c=3), RAM[1]=NOOP_WAIT(a=0), start pc=0, rdy tied high -> one o_inst_val pulse 5 cycles after start carrying the ADD instruction, then IDLE with o_busy 0 one instruction later.
REQ-043 The bench SHALL cover: RAM[0]=MUL_ELEMENT, i_inst_rdy held low for 7 cycles -> o_inst_val high 8 cycles with o_inst constant, exactly one transfer, pc becomes 1.
REQ-044 The bench SHALL cover: RAM[0]=NOOP_WAIT(a=4), RAM[1]=SEND_INTERRUPT(a=16'h00AB) -> exactly 4 DELAY cycles, then one o_irq pulse with o_irq_idx=16'h00AB.
REQ-045 The bench SHALL cover: start pc=2^ADDR_W-1 holding SUB_ELEMENT, RAM[0]=NOOP_WAIT(a=0) -> the next fetch address is 0, then IDLE.
REQ-046 The bench SHALL cover: opcode 8'h7F at pc=0 -> o_err=1, IDLE, no o_inst_val; a subsequent i_start clears o_err.
REQ-047 The bench SHALL cover: i_abort asserted during WAIT_RD and during DISPATCH -> IDLE next cycle, no transfer, and the late read data does not cause a dispatch.

Source files
------------

// File: rtl/bls12_381_pkg.sv
// Shared types for the BLS12-381 coprocessor.
// Instruction format, opcodes and fetch-unit timing constants.
package bls12_381_pkg;

   localparam int READ_CYCLE     = 3;
   // Instruction RAM address bits.
   localparam int INST_RAM_DEPTH = 8;

   typedef enum logic [7:0] {
      NOOP_WAIT       = 8'h00,
      COPY_REG        = 8'h01,
      SEND_INTERRUPT  = 8'h02,
      SUB_ELEMENT     = 8'h03,
      ADD_ELEMENT     = 8'h04,
      MUL_ELEMENT     = 8'h05,
      INV_ELEMENT     = 8'h06,
      POINT_MULT      = 8'h07,
      FP_FPOINT_MULT  = 8'h08,
      FP2_FPOINT_MULT = 8'h09
   } code_t;

   typedef struct packed {
      code_t       code;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] c;
   } inst_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT_RD,
      S_DECODE,
      S_DISPATCH,
      S_DELAY
   } fetch_state_t;

endpackage

// File: rtl/bls12_381_inst_fetch.sv
// Instruction fetch/decode sequencer: reads program RAM,
// dispatches ops, handles waits, interrupts and aborts.
module bls12_381_inst_fetch
   import bls12_381_pkg::*;
#(
   parameter int READ_CYCLE = bls12_381_pkg::READ_CYCLE,
   parameter int ADDR_W     = INST_RAM_DEPTH
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic                      i_start,
   input  logic [ADDR_W-1:0]         i_start_pc,
   input  logic                      i_abort,
   output logic [ADDR_W-1:0]         o_ram_addr,
   output logic                      o_ram_re,
   input  logic [$bits(inst_t)-1:0]  i_ram_dat,
   output logic [$bits(inst_t)-1:0]  o_inst,
   output logic                      o_inst_val,
   input  logic                      i_inst_rdy,
   output logic                      o_irq,
   output logic [15:0]               o_irq_idx,
   output logic                      o_busy,
   output logic                      o_err,
   output logic [ADDR_W-1:0]         o_pc
);

   localparam int RD_W = $clog2(READ_CYCLE + 1);

   fetch_state_t      state, state_n;
   logic [ADDR_W-1:0] pc;
   logic [RD_W-1:0]   rd_cnt;
   logic [15:0]       dly_cnt;
   inst_t             inst_q;
   logic              err_q;

   logic ram_re;
   logic start_go;
   logic capture;
   logic advance;
   logic dly_load;
   logic set_err;
   logic irq;

   always_comb begin
      state_n  = state;
      ram_re   = 1'b0;
      start_go = 1'b0;
      capture  = 1'b0;
      advance  = 1'b0;
      dly_load = 1'b0;
      set_err  = 1'b0;
      irq      = 1'b0;
      // A read left over from an abort must drain before a new one.
      if (state == S_FETCH && rd_cnt == '0)
         ram_re = 1'b1;
      if (i_abort) begin
         state_n = S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (i_start) begin
                  start_go = 1'b1;
                  state_n  = S_FETCH;
               end
            end
            S_FETCH: begin
               if (ram_re)
                  state_n = S_WAIT_RD;
            end
            S_WAIT_RD: begin
               if (rd_cnt == RD_W'(1)) begin
                  capture = 1'b1;
                  state_n = S_DECODE;
               end
            end
            S_DECODE: begin
               case (inst_q.code)
                  NOOP_WAIT: begin
                     if (inst_q.a == 16'd0) begin
                        state_n = S_IDLE;
                     end else begin
                        dly_load = 1'b1;
                        state_n  = S_DELAY;
                     end
                  end
                  SEND_INTERRUPT: begin
                     irq     = 1'b1;
                     advance = 1'b1;
                  end
                  COPY_REG, SUB_ELEMENT, ADD_ELEMENT,
                  MUL_ELEMENT, INV_ELEMENT, POINT_MULT,
                  FP_FPOINT_MULT, FP2_FPOINT_MULT: begin
                     state_n = S_DISPATCH;
                  end
                  default: begin
                     set_err = 1'b1;
                     state_n = S_IDLE;
                  end
               endcase
            end
            S_DISPATCH: begin
               if (i_inst_rdy)
                  advance = 1'b1;
            end
            S_DELAY: begin
               if (dly_cnt == 16'd1)
                  advance = 1'b1;
            end
            default: state_n = S_IDLE;
         endcase
         if (advance)
            state_n = S_FETCH;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         state <= S_IDLE;
      else
         state <= state_n;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pc      <= '0;
         rd_cnt  <= '0;
         dly_cnt <= '0;
         inst_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         if (ram_re)
            rd_cnt <= RD_W'(READ_CYCLE);
         else if (rd_cnt != '0)
            rd_cnt <= rd_cnt - RD_W'(1);

         if (start_go)
            pc <= i_start_pc;
         else if (advance)
            pc <= pc + ADDR_W'(1);

         if (start_go)
            err_q <= 1'b0;
         else if (set_err)
            err_q <= 1'b1;

         if (capture)
            inst_q <= inst_t'(i_ram_dat);

         if (i_abort)
            dly_cnt <= '0;
         else if (dly_load)
            dly_cnt <= inst_q.a;
         else if (state == S_DELAY)
            dly_cnt <= dly_cnt - 16'd1;
      end
   end

   assign o_ram_addr = pc;
   assign o_ram_re   = ram_re;
   assign o_inst     = inst_q;
   assign o_inst_val = (state == S_DISPATCH);
   assign o_irq      = irq;
   assign o_irq_idx  = inst_q.a;
   assign o_busy     = (state != S_IDLE);
   assign o_err      = err_q;
   assign o_pc       = pc;

endmodule

// File: tb/tb_bls12_381_inst_fetch.sv
// Directed bench for the instruction fetch sequencer with a
// fixed three-cycle instruction RAM model.
module tb_bls12_381_inst_fetch;
   import bls12_381_pkg::*;

   localparam int AW = 8;
   localparam int IW = 56;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [AW-1:0] start_pc;
   logic          abort;
   logic [AW-1:0] ram_addr;
   logic          ram_re;
   logic [IW-1:0] ram_dat;
   logic [IW-1:0] inst;
   logic          inst_val;
   logic          inst_rdy;
   logic          irq;
   logic [15:0]   irq_idx;
   logic          busy;
   logic          err;
   logic [AW-1:0] pc;

   logic [IW-1:0] ram [0:255];
   logic          v0, v1, v2;
   logic [AW-1:0] a0, a1, a2;
   int            xfer_cnt;
   int            irq_cnt;
   int            errors;
   int            checks;

   always #5 clk = ~clk;

   bls12_381_inst_fetch dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_start    (start),
      .i_start_pc (start_pc),
      .i_abort    (abort),
      .o_ram_addr (ram_addr),
      .o_ram_re   (ram_re),
      .i_ram_dat  (ram_dat),
      .o_inst     (inst),
      .o_inst_val (inst_val),
      .i_inst_rdy (inst_rdy),
      .o_irq      (irq),
      .o_irq_idx  (irq_idx),
      .o_busy     (busy),
      .o_err      (err),
      .o_pc       (pc)
   );

   // Data appears three cycles after the strobe; otherwise poison.
   always @(posedge clk) begin
      v0 <= ram_re;
      a0 <= ram_addr;
      v1 <= v0;
      a1 <= a0;
      v2 <= v1;
      a2 <= a1;
      if (inst_val && inst_rdy)
         xfer_cnt <= xfer_cnt + 1;
      if (irq)
         irq_cnt <= irq_cnt + 1;
   end

   assign ram_dat = v2 ? ram[a2] : {IW{1'b1}};

   function automatic logic [IW-1:0] mk(input logic [7:0] c,
                                        input logic [15:0] a,
                                        input logic [15:0] b,
                                        input logic [15:0] cc);
      return {c, a, b, cc};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (busy && n < 30) begin
         step();
         n++;
      end
      chk(tag, 64'(busy), 64'd0);
   endtask

   task automatic kick(input logic [AW-1:0] p);
      start_pc = p;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   initial begin
      int x0;
      int re_at;
      int irq_at;
      logic [15:0] idx_at;
      errors = 0;
      checks = 0;
      xfer_cnt = 0;
      irq_cnt = 0;
      v0 = 0; v1 = 0; v2 = 0;
      a0 = '0; a1 = '0; a2 = '0;
      for (int i = 0; i < 256; i++)
         ram[i] = mk(8'h00, 16'd0, 16'd0, 16'd0);
      rst_n = 1'b0;
      start = 1'b0;
      start_pc = 8'h5A;
      abort = 1'b0;
      inst_rdy = 1'b1;
      step();
      step();
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_pc", 64'(pc), 64'd0);
      chk("rst_addr", 64'(ram_addr), 64'd0);
      chk("rst_re", 64'(ram_re), 64'd0);
      chk("rst_inst", 64'(inst), 64'd0);
      chk("rst_val", 64'(inst_val), 64'd0);
      chk("rst_irq", {63'd0, irq}, 64'd0);
      chk("rst_idx", 64'(irq_idx), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      rst_n = 1'b1;
      step();
      step();
      chk("no_self_start", 64'(busy), 64'd0);

      // ADD then end of program, ready tied high
      ram[0] = mk(8'h04, 16'd1, 16'd2, 16'd3);
      ram[1] = mk(8'h00, 16'd0, 16'd0, 16'd0);
      x0 = xfer_cnt;
      kick(8'd0);
      chk("t1_re", 64'(ram_re), 64'd1);
      chk("t1_addr", 64'(ram_addr), 64'd0);
      for (int i = 1; i <= 4; i++) begin
         step();
         chk("t1_val_early", 64'(inst_val), 64'd0);
      end
      step();
      chk("t1_val", 64'(inst_val), 64'd1);
      chk("t1_inst", 64'(inst), 64'h04_0001_0002_0003);
      step();
      chk("t1_val_drop", 64'(inst_val), 64'd0);
      chk("t1_pc", 64'(pc), 64'd1);
      chk("t1_re2", 64'(ram_re), 64'd1);
      for (int i = 1; i <= 4; i++)
         step();
      chk("t1_busy_dec", 64'(busy), 64'd1);
      step();
      chk("t1_idle", 64'(busy), 64'd0);
      chk("t1_xfers", 64'(xfer_cnt - x0), 64'd1);

      // MUL with back-pressure for seven cycles
      ram[0] = mk(8'h05, 16'd5, 16'd6, 16'd7);
      inst_rdy = 1'b0;
      x0 = xfer_cnt;
      kick(8'd0);
      for (int i = 1; i <= 5; i++)
         step();
      for (int i = 0; i < 7; i++) begin
         chk("t2_val_hold", 64'(inst_val), 64'd1);
         chk("t2_inst_hold", 64'(inst), 64'h05_0005_0006_0007);
         step();
      end
      inst_rdy = 1'b1;
      chk("t2_val_last", 64'(inst_val), 64'd1);
      chk("t2_inst_last", 64'(inst), 64'h05_0005_0006_0007);
      step();
      chk("t2_val_drop", 64'(inst_val), 64'd0);
      chk("t2_pc", 64'(pc), 64'd1);
      wait_idle("t2_idle");
      chk("t2_xfers", 64'(xfer_cnt - x0), 64'd1);

      // wait 4, interrupt 0xAB, end
      ram[0] = mk(8'h00, 16'd4, 16'd0, 16'd0);
      ram[1] = mk(8'h02, 16'h00AB, 16'd0, 16'd0);
      ram[2] = mk(8'h00, 16'd0, 16'd0, 16'd0);
      x0 = irq_cnt;
      re_at = -1;
      irq_at = -1;
      idx_at = '0;
      kick(8'd0);
      for (int i = 1; i <= 14; i++) begin
         step();
         if (ram_re && re_at < 0)
            re_at = i;
         if (irq && irq_at < 0) begin
            irq_at = i;
            idx_at = irq_idx;
         end
      end
      chk("t3_refetch_at", 64'(re_at), 64'd9);
      chk("t3_irq_at", 64'(irq_at), 64'd13);
      chk("t3_irq_idx", 64'(idx_at), 64'h00AB);
      wait_idle("t3_idle");
      chk("t3_irq_cnt", 64'(irq_cnt - x0), 64'd1);

      // pc wrap from the top address
      ram[255] = mk(8'h03, 16'd9, 16'd9, 16'd9);
      ram[0]   = mk(8'h00, 16'd0, 16'd0, 16'd0);
      kick(8'hFF);
      chk("t4_addr_top", 64'(ram_addr), 64'hFF);
      for (int i = 1; i <= 5; i++)
         step();
      chk("t4_inst", 64'(inst), 64'h03_0009_0009_0009);
      step();
      chk("t4_re_wrap", 64'(ram_re), 64'd1);
      chk("t4_addr_wrap", 64'(ram_addr), 64'd0);
      wait_idle("t4_idle");

      // illegal opcode
      ram[0] = mk(8'h7F, 16'd1, 16'd1, 16'd1);
      x0 = xfer_cnt;
      kick(8'd0);
      for (int i = 1; i <= 4; i++)
         step();
      chk("t5_err_pre", 64'(err), 64'd0);
      step();
      chk("t5_err", 64'(err), 64'd1);
      chk("t5_idle", 64'(busy), 64'd0);
      chk("t5_no_xfer", 64'(xfer_cnt - x0), 64'd0);
      step();
      chk("t5_sticky", 64'(err), 64'd1);
      ram[0] = mk(8'h00, 16'd0, 16'd0, 16'd0);
      kick(8'd0);
      chk("t5_err_clr", 64'(err), 64'd0);
      wait_idle("t5_idle2");

      // abort in WAIT_RD
      ram[0] = mk(8'h04, 16'd1, 16'd2, 16'd3);
      x0 = xfer_cnt;
      kick(8'd0);
      step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("t6_abort_idle", 64'(busy), 64'd0);
      chk("t6_abort_val", 64'(inst_val), 64'd0);
      for (int i = 0; i < 6; i++)
         step();
      chk("t6_late_busy", 64'(busy), 64'd0);
      chk("t6_late_xfer", 64'(xfer_cnt - x0), 64'd0);

      // abort in DISPATCH
      inst_rdy = 1'b0;
      kick(8'd0);
      for (int i = 1; i <= 5; i++)
         step();
      chk("t6_disp_val", 64'(inst_val), 64'd1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      inst_rdy = 1'b1;
      chk("t6_disp_abort_val", 64'(inst_val), 64'd0);
      chk("t6_disp_abort_busy", 64'(busy), 64'd0);
      chk("t6_disp_abort_pc", 64'(pc), 64'd0);
      step();
      step();
      chk("t6_disp_xfer", 64'(xfer_cnt - x0), 64'd0);

      // start together with abort
      start = 1'b1;
      abort = 1'b1;
      step();
      start = 1'b0;
      abort = 1'b0;
      chk("t7_abort_wins", 64'(busy), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
